// File: rtl/riscv_pkg.sv
// Shared core definitions: memory access width limit and the wide-access sequencer states.
package riscv_pkg;

    localparam int MaxMemAccessWidth = 128;

    typedef enum logic [1:0] {
        WM_IDLE,
        WM_LOAD,
        WM_STORE,
        WM_HOLD
    } wide_mem_state_e;

endpackage

// File: rtl/ma_wide_mem_seq.sv
// Splits a wide MA-stage load/store into consecutive bus-word accesses,
// stalling the pipeline while it overrides the memory port.
//
// state    | meaning
// WM_IDLE  | no sequence; accept a wide request this cycle if aligned
// WM_LOAD  | capturing read beats, issuing the next read address
// WM_STORE | writing store beats, one per cycle
// WM_HOLD  | sequence done; load result valid until the instruction advances
module ma_wide_mem_seq
    import riscv_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int MAX_WIDTH = MaxMemAccessWidth,
    localparam int MAX_BEATS = MAX_WIDTH / XLEN,
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_stall,
    input  logic                 i_req_valid,
    input  logic                 i_req_is_store,
    input  logic [BEAT_W-1:0]    i_req_beats,
    input  logic [XLEN-1:0]      i_req_addr,
    input  logic [MAX_WIDTH-1:0] i_req_wdata,
    input  logic                 i_box_ones,
    input  logic [XLEN-1:0]      i_mem_rdata,
    output logic                 o_stall,
    output logic                 o_mem_override,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic [XLEN-1:0]      o_mem_wdata,
    output logic [XLEN/8-1:0]    o_mem_we,
    output logic [MAX_WIDTH-1:0] o_load_data,
    output logic                 o_load_valid,
    output logic                 o_misaligned
);

    localparam int BYTES = XLEN / 8;
    localparam int BSH   = $clog2(BYTES);

    wide_mem_state_e      state;
    logic [BEAT_W-1:0]    cnt;
    logic [BEAT_W-1:0]    beats_r;
    logic [XLEN-1:0]      addr_r;
    logic [MAX_WIDTH-1:0] wdata_r;
    logic                 box_r;
    logic                 is_store_r;
    logic [MAX_WIDTH-1:0] beat_buf;
    logic [MAX_WIDTH-1:0] load_data_r;

    logic                 beats_ok;
    logic                 beats_pow2;
    logic                 aligned;
    logic                 req_live;
    logic                 accept;
    logic                 last_beat;
    logic [XLEN-1:0]      size_mask;
    logic [XLEN-1:0]      cnt_off;
    logic [XLEN-1:0]      store_beat;
    logic [MAX_WIDTH-1:0] buf_next;
    logic [MAX_WIDTH-1:0] asm_data;

    always_comb begin
        beats_ok   = (i_req_beats >= BEAT_W'(2)) && (i_req_beats <= BEAT_W'(MAX_BEATS));
        beats_pow2 = (i_req_beats & (i_req_beats - BEAT_W'(1))) == '0;
        size_mask  = (XLEN'(i_req_beats) << BSH) - XLEN'(1);
        aligned    = beats_pow2 ? ((i_req_addr & size_mask) == '0)
                                : (i_req_addr[BSH-1:0] == '0);
        req_live   = i_rst_n && (state == WM_IDLE) && i_req_valid && beats_ok;
        accept     = req_live && aligned && !i_flush;
        last_beat  = (cnt == beats_r - BEAT_W'(1));
        cnt_off    = XLEN'(cnt) << BSH;
    end

    // Beat selection by counter; slots at or above the beat count take the fill pattern.
    always_comb begin
        store_beat = '0;
        buf_next   = beat_buf;
        asm_data   = '0;
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (BEAT_W'(i) == cnt) begin
                store_beat                 = wdata_r[i*XLEN +: XLEN];
                buf_next[i*XLEN +: XLEN] = i_mem_rdata;
            end
        end
        for (int i = 0; i < MAX_BEATS; i++) begin
            asm_data[i*XLEN +: XLEN] = (BEAT_W'(i) < beats_r) ? buf_next[i*XLEN +: XLEN]
                                                                : {XLEN{box_r}};
        end
    end

    always_comb begin
        o_stall        = 1'b0;
        o_mem_override = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_mem_we       = '0;
        if (i_rst_n && !i_flush) begin
            unique case (state)
                WM_IDLE: begin
                    if (accept) begin
                        o_stall        = 1'b1;
                        o_mem_override = 1'b1;
                        if (i_req_is_store) begin
                            o_mem_addr  = i_req_addr;
                            o_mem_wdata = i_req_wdata[XLEN-1:0];
                            o_mem_we    = '1;
                        end else begin
                            o_mem_addr = i_req_addr + XLEN'(BYTES);
                        end
                    end
                end
                WM_LOAD: begin
                    o_stall = 1'b1;
                    if (!last_beat) begin
                        o_mem_override = 1'b1;
                        o_mem_addr     = addr_r + cnt_off + XLEN'(BYTES);
                    end
                end
                WM_STORE: begin
                    o_stall        = 1'b1;
                    o_mem_override = 1'b1;
                    o_mem_addr     = addr_r + cnt_off;
                    o_mem_wdata    = store_beat;
                    o_mem_we       = '1;
                end
                default: ;
            endcase
        end
    end

    assign o_misaligned = req_live && !aligned;
    assign o_load_valid = i_rst_n && (state == WM_HOLD) && !is_store_r;
    assign o_load_data  = load_data_r;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= WM_IDLE;
            cnt         <= '0;
            beats_r     <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            box_r       <= 1'b0;
            is_store_r  <= 1'b0;
            beat_buf    <= '0;
            load_data_r <= '0;
        end else if (i_flush) begin
            state <= WM_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                WM_IDLE: begin
                    if (accept) begin
                        addr_r     <= i_req_addr;
                        beats_r    <= i_req_beats;
                        wdata_r    <= i_req_wdata;
                        box_r      <= i_box_ones;
                        is_store_r <= i_req_is_store;
                        beat_buf   <= buf_next;
                        cnt        <= BEAT_W'(1);
                        state      <= i_req_is_store ? WM_STORE : WM_LOAD;
                    end
                end
                WM_LOAD: begin
                    beat_buf <= buf_next;
                    if (last_beat) begin
                        load_data_r <= asm_data;
                        state       <= WM_HOLD;
                    end else begin
                        cnt <= cnt + BEAT_W'(1);
                    end
                end
                WM_STORE: begin
                    if (last_beat) state <= WM_HOLD;
                    else           cnt   <= cnt + BEAT_W'(1);
                end
                WM_HOLD: begin
                    if (!i_stall || !i_req_valid) begin
                        state <= WM_IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= WM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_wide_mem_seq.sv
// Scoreboard bench for ma_wide_mem_seq: a driver pushes expected writes, loads and
// stall lengths; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_ma_wide_mem_seq;

    localparam int XLEN      = 32;
    localparam int MAX_WIDTH = 128;
    localparam int MAX_BEATS = 4;
    localparam int BEAT_W    = 3;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_flush = 1'b0;
    logic                 i_stall;
    logic                 i_req_valid = 1'b0;
    logic                 i_req_is_store = 1'b0;
    logic [BEAT_W-1:0]    i_req_beats = '0;
    logic [XLEN-1:0]      i_req_addr = '0;
    logic [MAX_WIDTH-1:0] i_req_wdata = '0;
    logic                 i_box_ones = 1'b0;
    logic [XLEN-1:0]      i_mem_rdata = '0;
    logic                 o_stall;
    logic                 o_mem_override;
    logic [XLEN-1:0]      o_mem_addr;
    logic [XLEN-1:0]      o_mem_wdata;
    logic [XLEN/8-1:0]    o_mem_we;
    logic [MAX_WIDTH-1:0] o_load_data;
    logic                 o_load_valid;
    logic                 o_misaligned;

    logic ext_stall = 1'b0;
    assign i_stall = o_stall | ext_stall;

    ma_wide_mem_seq #(.XLEN(XLEN), .MAX_WIDTH(MAX_WIDTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_stall(i_stall),
        .i_req_valid(i_req_valid), .i_req_is_store(i_req_is_store),
        .i_req_beats(i_req_beats), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_box_ones(i_box_ones), .i_mem_rdata(i_mem_rdata), .o_stall(o_stall),
        .o_mem_override(o_mem_override), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_load_data(o_load_data),
        .o_load_valid(o_load_valid), .o_misaligned(o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t                  exp_wr[$];
    logic [MAX_WIDTH-1:0] exp_load[$];
    int                   exp_stall[$];
    int                   exp_mis[$];
    logic [31:0]          mem[logic [31:0]];
    int                   checks = 0;
    int                   errors = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Memory: read data returns one cycle after the address presented.
    logic [31:0] pend_addr = '0;
    always @(posedge i_clk) i_mem_rdata <= rd(pend_addr);

    int                   run = 0;
    logic                 prev_lv = 1'b0;
    logic [MAX_WIDTH-1:0] held = '0;
    wr_t                  w_exp;
    int                   s_exp;

    always @(negedge i_clk) begin
        pend_addr = o_mem_override ? o_mem_addr : i_req_addr;
        if (!i_rst_n) begin
            run     = 0;
            prev_lv = 1'b0;
        end else begin
            if (o_mem_we != '0) begin
                if (exp_wr.size() == 0) unexpected("write", {o_mem_addr, o_mem_wdata});
                else begin
                    w_exp = exp_wr.pop_front();
                    chk("wr_addr", o_mem_addr, w_exp.addr);
                    chk("wr_data", o_mem_wdata, w_exp.data);
                    chk("wr_we", o_mem_we, 4'hF);
                    chk("wr_override", o_mem_override, 1);
                end
                mem[o_mem_addr] = o_mem_wdata;
            end
            if (o_stall) run++;
            else if (run > 0) begin
                if (exp_stall.size() == 0) unexpected("stall_run", run);
                else begin
                    s_exp = exp_stall.pop_front();
                    chk("stall_len", run, s_exp);
                end
                run = 0;
            end
            if (o_misaligned) begin
                if (exp_mis.size() == 0) unexpected("misaligned", o_misaligned);
                else void'(exp_mis.pop_front());
                chk("mis_stall", o_stall, 0);
                chk("mis_override", o_mem_override, 0);
            end
            if (o_load_valid && !prev_lv) begin
                if (exp_load.size() == 0) unexpected("load_valid", o_load_data);
                else begin
                    held = exp_load.pop_front();
                    chk("load_data", o_load_data, held);
                end
            end else if (o_load_valid) begin
                chk("load_hold", o_load_data, held);
            end
            prev_lv = o_load_valid;
        end
    end

    task automatic do_req(input bit st, input int beats, input logic [31:0] addr,
                          input logic [127:0] wd, input bit box, input int hold_extra,
                          input int flush_at);
        bit                   al;
        int                   n;
        logic [MAX_WIDTH-1:0] ld;
        i_req_valid    = 1'b0;
        i_req_addr     = addr;
        i_req_is_store = st;
        i_req_beats    = BEAT_W'(beats);
        i_req_wdata    = wd;
        i_box_ones     = box;
        @(posedge i_clk); #1;
        al = (beats == 2 || beats == 4) ? (addr % (beats * 4) == 0) : (addr % 4 == 0);
        i_req_valid = 1'b1;
        if (beats < 2 || beats > MAX_BEATS || !al) begin
            if (beats >= 2 && beats <= MAX_BEATS) exp_mis.push_back(1);
            @(posedge i_clk); #1;
            i_req_valid = 1'b0;
            return;
        end
        if (flush_at >= 0) begin
            for (int k = 0; k < flush_at; k++)
                if (st) exp_wr.push_back({addr + 32'(4 * k), wd[k*32 +: 32]});
            if (flush_at > 0) exp_stall.push_back(flush_at);
            repeat (flush_at) @(posedge i_clk);
            #1 i_flush = 1'b1;
            @(posedge i_clk); #1;
            i_flush     = 1'b0;
            i_req_valid = 1'b0;
            @(negedge i_clk);
            chk("post_flush_stall", o_stall, 0);
            return;
        end
        ld = '0;
        for (int k = 0; k < MAX_BEATS; k++) begin
            if (k < beats) begin
                if (st) exp_wr.push_back({addr + 32'(4 * k), wd[k*32 +: 32]});
                else    ld[k*32 +: 32] = rd(addr + 32'(4 * k));
            end else begin
                ld[k*32 +: 32] = box ? 32'hFFFF_FFFF : 32'h0;
            end
        end
        if (!st) exp_load.push_back(ld);
        exp_stall.push_back(beats);
        ext_stall = (hold_extra > 0);
        @(negedge i_clk);
        if (!st) begin
            chk("rd_override", o_mem_override, 1);
            chk("rd_addr", o_mem_addr, addr + 32'd4);
        end
        n = 1;
        while (o_stall && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (o_stall) unexpected("stall_timeout", n);
        repeat (hold_extra) @(negedge i_clk);
        ext_stall = 1'b0;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("idle_after_hold", o_load_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st, beats, r, hold, fl;
        logic [31:0] addr;

        // Outputs must be quiet in reset even with a misaligned wide request present.
        i_req_valid = 1'b1;
        i_req_beats = 3'd2;
        i_req_addr  = 32'h102;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_stall", o_stall, 0);
        chk("rst_override", o_mem_override, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_misaligned", o_misaligned, 0);
        chk("rst_load_valid", o_load_valid, 0);
        chk("rst_load_data", o_load_data, 0);
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        mem[32'h100] = 32'hAAAA_0001;
        mem[32'h104] = 32'hBBBB_0002;
        do_req(0, 2, 32'h100, '0, 1, 0, -1);
        do_req(1, 4, 32'h200, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, -1);
        do_req(0, 4, 32'h108, '0, 0, 0, -1);
        do_req(0, 4, 32'h110, '0, 0, 0, -1);
        do_req(1, 4, 32'h200, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 0, 0, 2);
        do_req(0, 3, 32'h204, '0, 1, 3, -1);
        do_req(0, 1, 32'h100, '0, 0, 0, -1);
        do_req(1, 0, 32'h100, '0, 0, 0, -1);

        // Reset mid-load: sequence abandoned, nothing further written.
        i_req_addr     = 32'h300;
        i_req_is_store = 1'b0;
        i_req_beats    = 3'd4;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_stall", o_stall, 0);
        chk("midrst_override", o_mem_override, 0);
        chk("midrst_load_valid", o_load_valid, 0);
        chk("midrst_load_data", o_load_data, 0);
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("postrst_stall", o_stall, 0);

        do_req(0, 2, 32'hFFFF_FFF8, '0, 0, 0, -1);
        do_req(1, 2, 32'hFFFF_FFF8, {$urandom, $urandom, $urandom, $urandom}, 0, 0, -1);

        for (int t = 0; t < 80; t++) begin
            st    = int'($urandom_range(0, 1));
            beats = int'($urandom_range(0, 4));
            addr  = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            r     = int'($urandom_range(0, 3));
            if (r == 0)      addr = addr + 32'($urandom_range(1, 3));
            else if (r == 1) addr = addr & ~32'hF;
            hold = int'($urandom_range(0, 2));
            fl   = -1;
            if (beats >= 2 && $urandom_range(0, 7) == 0) fl = int'($urandom_range(0, beats - 1));
            do_req(st[0], beats, addr, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 1) == 1, hold, fl);
        end

        repeat (3) @(posedge i_clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_loads", exp_load.size(), 0);
        chk("pending_stalls", exp_stall.size(), 0);
        chk("pending_misaligned", exp_mis.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
